// File: rtl/mrna_iso_pkg.sv
// Shared state encoding, valve indices and per-state open-valve decode
// for the mRNA isolation sequencer.
package mrna_iso_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_LOAD    = 4'd1,
    ST_BEADS   = 4'd2,
    ST_LYSE    = 4'd3,
    ST_MIX     = 4'd4,
    ST_SEP     = 4'd5,
    ST_COLLECT = 4'd6,
    ST_FLUSH   = 4'd7,
    ST_DONE    = 4'd8
  } state_e;

  localparam int unsigned NVALVE      = 13;
  localparam int unsigned V_COLLECT   = 0;
  localparam int unsigned V_LYSIS_IN  = 1;
  localparam int unsigned V_LYSIS_OUT = 2;
  localparam int unsigned V_PUSH      = 3;
  localparam int unsigned V_PUMP1     = 4;
  localparam int unsigned V_PUMP2     = 5;
  localparam int unsigned V_PUMP3     = 6;
  localparam int unsigned V_SEP       = 7;
  localparam int unsigned V_SIEVE     = 8;
  localparam int unsigned V_WASTE     = 9;
  localparam int unsigned V_BEADS     = 10;
  localparam int unsigned V_CELLS_IN  = 11;
  localparam int unsigned V_CELLS_OUT = 12;

  // Valves that are open (not actuated) in a state; MIX pump valves are
  // supplied separately by the pump generator.
  function automatic logic [NVALVE-1:0] open_mask(input state_e s);
    logic [NVALVE-1:0] m;
    m = '0;
    case (s)
      ST_LOAD:    begin m[V_CELLS_IN] = 1'b1;  m[V_CELLS_OUT] = 1'b1; end
      ST_BEADS:   begin m[V_BEADS] = 1'b1;     m[V_CELLS_OUT] = 1'b1; end
      ST_LYSE:    begin m[V_LYSIS_IN] = 1'b1;  m[V_LYSIS_OUT] = 1'b1; end
      ST_SEP:     begin m[V_WASTE] = 1'b1; end
      ST_COLLECT: begin m[V_PUSH] = 1'b1;      m[V_COLLECT] = 1'b1; end
      default:    m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mrna_iso_pump3.sv
// Three-phase peristaltic pump pattern generator. Held in phase 0 while
// disabled; flags the final cycle of the final rotation.
module mrna_iso_pump3 #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_t_step,
  input  logic [CNT_W-1:0] i_mix_cyc,
  output logic [2:0]       o_open,
  output logic             o_last
);

  logic [1:0]       r_phase;
  logic [CNT_W-1:0] r_step;
  logic [CNT_W-1:0] r_rot;
  logic [CNT_W-1:0] w_step_max;
  logic [CNT_W-1:0] w_rot_max;
  logic             w_phase_end;

  // Zero step time or rotation count behaves as one.
  assign w_step_max  = (i_t_step  == '0) ? '0 : i_t_step  - 1'b1;
  assign w_rot_max   = (i_mix_cyc == '0) ? '0 : i_mix_cyc - 1'b1;
  assign w_phase_end = (r_step == w_step_max);
  assign o_last      = i_en && (r_phase == 2'd2) && w_phase_end && (r_rot == w_rot_max);

  // Step, phase and rotation counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
      r_step  <= '0;
      r_rot   <= '0;
    end else if (!i_en) begin
      r_phase <= '0;
      r_step  <= '0;
      r_rot   <= '0;
    end else if (w_phase_end) begin
      r_step <= '0;
      if (r_phase == 2'd2) begin
        r_phase <= '0;
        r_rot   <= r_rot + 1'b1;
      end else begin
        r_phase <= r_phase + 1'b1;
      end
    end else begin
      r_step <= r_step + 1'b1;
    end
  end

  // Open pattern ordered {p1,p2,p3}: 011 -> 001 -> 100.
  always_comb begin
    case (r_phase)
      2'd0:    o_open = 3'b011;
      2'd1:    o_open = 3'b001;
      default: o_open = 3'b100;
    endcase
  end

endmodule

// File: rtl/mrna_iso_seq.sv
// Protocol sequencer for NCH parallel mRNA isolation banks:
// load -> beads -> lyse -> mix -> separate -> collect -> flush -> done.
module mrna_iso_seq
  import mrna_iso_pkg::*;
#(
  parameter int unsigned NCH     = 1,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned T_LOAD  = 8,
  parameter int unsigned T_BEADS = 4,
  parameter int unsigned T_LYSE  = 8,
  parameter int unsigned T_STEP  = 2,
  parameter int unsigned MIX_CYC = 3,
  parameter int unsigned T_SEP   = 6,
  parameter int unsigned T_COLL  = 5,
  parameter int unsigned T_FLUSH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NCH-1:0]        chan_en,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [3:0]            state_o,
  output logic [NCH*NVALVE-1:0] valve_ctrl,
  output logic [NCH*NVALVE-1:0] flush
);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [NCH-1:0]    r_mask;
  logic              r_busy;
  logic              r_done;
  logic              r_aborted;
  logic              r_abort_pend;
  logic [2:0]        w_pump_open;
  logic              w_pump_last;
  logic [NVALVE-1:0] w_open;

  // Dwell load value; a zero dwell behaves as one cycle.
  function automatic logic [CNT_W-1:0] dwell(input int unsigned t);
    return (t == 0) ? '0 : CNT_W'(t - 1);
  endfunction

  mrna_iso_pump3 #(.CNT_W(CNT_W)) u_pump (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (r_state == ST_MIX),
    .i_t_step  (CNT_W'(T_STEP)),
    .i_mix_cyc (CNT_W'(MIX_CYC)),
    .o_open    (w_pump_open),
    .o_last    (w_pump_last)
  );

  // Sequencer FSM with dwell counter, channel mask and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_mask       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_abort_pend <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            r_state      <= ST_LOAD;
            r_cnt        <= dwell(T_LOAD);
            r_mask       <= chan_en;
            r_busy       <= 1'b1;
            r_aborted    <= 1'b0;
            r_abort_pend <= 1'b0;
          end
        end
        ST_LOAD, ST_BEADS, ST_LYSE, ST_MIX, ST_SEP, ST_COLLECT: begin
          if (abort) begin
            r_state      <= ST_FLUSH;
            r_cnt        <= dwell(T_FLUSH);
            r_abort_pend <= 1'b1;
          end else if (r_state == ST_MIX) begin
            // MIX length is owned by the pump generator, not the dwell counter.
            if (w_pump_last) begin
              r_state <= ST_SEP;
              r_cnt   <= dwell(T_SEP);
            end
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            case (r_state)
              ST_LOAD:  begin r_state <= ST_BEADS;   r_cnt <= dwell(T_BEADS); end
              ST_BEADS: begin r_state <= ST_LYSE;    r_cnt <= dwell(T_LYSE);  end
              ST_LYSE:  begin r_state <= ST_MIX;     r_cnt <= '0;             end
              ST_SEP:   begin r_state <= ST_COLLECT; r_cnt <= dwell(T_COLL);  end
              default:  begin r_state <= ST_FLUSH;   r_cnt <= dwell(T_FLUSH); end
            endcase
          end
        end
        ST_FLUSH: begin
          if (r_cnt == '0) begin
            r_state   <= ST_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_aborted <= r_abort_pend;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_mask  <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign aborted = r_aborted;
  assign state_o = r_state;

  // Open-valve set for the current state, with pump phases in MIX.
  always_comb begin
    w_open = open_mask(r_state);
    if (r_state == ST_MIX) begin
      w_open[V_PUMP1] = w_pump_open[2];
      w_open[V_PUMP2] = w_pump_open[1];
      w_open[V_PUMP3] = w_pump_open[0];
    end
  end

  // Per-channel replication; disabled channels stay fully closed.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign valve_ctrl[c*NVALVE +: NVALVE] = r_mask[c] ? ~w_open : '1;
    assign flush[c*NVALVE +: NVALVE]      = (r_mask[c] && r_state == ST_FLUSH) ? '1 : '0;
  end

endmodule
